// File: rtl/copro_initiator_if.sv
// Core-to-coprocessor bundle: request, coprocessor drive/return and result signals.
interface copro_initiator_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned OPC_W  = 3;
   localparam int unsigned OP_W   = 2;

   // request from the core
   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_is_mrc;
   logic [REG_W-1:0]  i_req_num;
   logic [REG_W-1:0]  i_req_crn;
   logic [REG_W-1:0]  i_req_crm;
   logic [OPC_W-1:0]  i_req_opcode1;
   logic [OPC_W-1:0]  i_req_opcode2;
   logic [REG_W-1:0]  i_req_rd;
   logic [DATA_W-1:0] i_req_wdata;

   // coprocessor side
   logic [OP_W-1:0]   o_copro_operation;
   logic [REG_W-1:0]  o_copro_num;
   logic [REG_W-1:0]  o_copro_crn;
   logic [REG_W-1:0]  o_copro_crm;
   logic [OPC_W-1:0]  o_copro_opcode1;
   logic [OPC_W-1:0]  o_copro_opcode2;
   logic [DATA_W-1:0] o_copro_write_data;
   logic [DATA_W-1:0] i_copro_read_data;

   // results back to the core
   logic              o_rdata_valid;
   logic [DATA_W-1:0] o_rdata;
   logic [REG_W-1:0]  o_rdata_rd;
   logic              o_undef;
   logic              o_busy;

   // initiator side
   modport slave (
      input  i_req_valid, i_req_is_mrc, i_req_num, i_req_crn, i_req_crm,
             i_req_opcode1, i_req_opcode2, i_req_rd, i_req_wdata, i_copro_read_data,
      output o_req_ready, o_copro_operation, o_copro_num, o_copro_crn, o_copro_crm,
             o_copro_opcode1, o_copro_opcode2, o_copro_write_data,
             o_rdata_valid, o_rdata, o_rdata_rd, o_undef, o_busy
   );

   // core / coprocessor side
   modport master (
      output i_req_valid, i_req_is_mrc, i_req_num, i_req_crn, i_req_crm,
             i_req_opcode1, i_req_opcode2, i_req_rd, i_req_wdata, i_copro_read_data,
      input  o_req_ready, o_copro_operation, o_copro_num, o_copro_crn, o_copro_crm,
             o_copro_opcode1, o_copro_opcode2, o_copro_write_data,
             o_rdata_valid, o_rdata, o_rdata_rd, o_undef, o_busy
   );
endinterface

// File: rtl/copro_initiator.sv
// Issues MRC/MCR operations to coprocessor 15 and returns MRC read data to the core.
module copro_initiator (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_fetch_stall,
   copro_initiator_if.slave  bus
);
   localparam int unsigned REG_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam logic [1:0]  OP_IDLE = 2'd0;
   localparam logic [1:0]  OP_MRC  = 2'd1;
   localparam logic [1:0]  OP_MCR  = 2'd2;
   localparam logic [REG_W-1:0] COPRO_NUM = REG_W'(15);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t           state;
   logic             is_mrc_q;
   logic [REG_W-1:0] rd_q;

   // Ready only when idle and the pipeline is moving; busy whenever a transfer is in flight.
   assign bus.o_req_ready = (state == ST_IDLE) && !i_fetch_stall;
   assign bus.o_busy      = (state != ST_IDLE);

   // Transfer FSM with registered outputs; everything holds while the pipeline is stalled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state                  <= ST_IDLE;
         is_mrc_q               <= 1'b0;
         rd_q                   <= '0;
         bus.o_copro_operation  <= OP_IDLE;
         bus.o_copro_num        <= '0;
         bus.o_copro_crn        <= '0;
         bus.o_copro_crm        <= '0;
         bus.o_copro_opcode1    <= '0;
         bus.o_copro_opcode2    <= '0;
         bus.o_copro_write_data <= '0;
         bus.o_rdata_valid      <= 1'b0;
         bus.o_rdata            <= '0;
         bus.o_rdata_rd         <= '0;
         bus.o_undef            <= 1'b0;
      end else if (!i_fetch_stall) begin
         // single-cycle pulses by default
         bus.o_undef       <= 1'b0;
         bus.o_rdata_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // in IDLE and unstalled, ready is high, so valid alone means accepted
               if (bus.i_req_valid) begin
                  if (bus.i_req_num == COPRO_NUM) begin
                     is_mrc_q               <= bus.i_req_is_mrc;
                     rd_q                   <= bus.i_req_rd;
                     bus.o_copro_num        <= bus.i_req_num;
                     bus.o_copro_crn        <= bus.i_req_crn;
                     bus.o_copro_crm        <= bus.i_req_crm;
                     bus.o_copro_opcode1    <= bus.i_req_opcode1;
                     bus.o_copro_opcode2    <= bus.i_req_opcode2;
                     bus.o_copro_write_data <= bus.i_req_is_mrc ? '0 : bus.i_req_wdata;
                     bus.o_copro_operation  <= bus.i_req_is_mrc ? OP_MRC : OP_MCR;
                     state                  <= ST_ISSUE;
                  end else begin
                     // no such coprocessor: flag undefined instruction, stay idle
                     bus.o_undef <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               // the operation is visible for exactly one moving cycle
               bus.o_copro_operation <= OP_IDLE;
               state                 <= is_mrc_q ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
               // register selectors are still held, so the read mux is stable here
               bus.o_rdata       <= DATA_W'(bus.i_copro_read_data);
               bus.o_rdata_rd    <= rd_q;
               bus.o_rdata_valid <= 1'b1;
               state             <= ST_IDLE;
            end
            default: begin
               bus.o_copro_operation <= OP_IDLE;
               state                 <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_copro_initiator.sv
// Randomized and directed check of copro_initiator against a transaction-level model.
module tb_copro_initiator;
   localparam logic [31:0] ID_REG     = 32'h4156_0300;
   localparam logic [31:0] FAULT_ADDR = 32'h0000_BAD0;

   logic clk = 1'b0;
   logic rst_n;
   logic stall;
   bit   chk_en = 1'b0;
   int   total = 0;
   int   bad   = 0;

   copro_initiator_if bus ();

   copro_initiator dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_fetch_stall (stall),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   // coprocessor stub register file and the model's own view of it
   logic [31:0] sregs [16];
   logic [31:0] mregs [16];
   assign bus.i_copro_read_data = sregs[bus.o_copro_crn];

   // model: positions of the last transfer in unstalled-edge time
   int unsigned ue;
   bit          m_has, m_mrc, m_undef_has, acc_evt;
   int unsigned m_acc_ue, m_undef_ue;
   logic [3:0]  m_num, m_crn, m_crm, m_rd, m_rdata_rd;
   logic [2:0]  m_o1, m_o2;
   logic [31:0] m_wd, m_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      return m_has && (ue == m_acc_ue || (m_mrc && ue == m_acc_ue + 1));
   endfunction

   task automatic m_reset();
      m_has = 0; m_mrc = 0; m_undef_has = 0;
      m_num = 0; m_crn = 0; m_crm = 0; m_rd = 0; m_o1 = 0; m_o2 = 0;
      m_wd = 0; m_rdata = 0; m_rdata_rd = 0;
   endtask

   // one unstalled edge of the model
   task automatic model_edge();
      acc_evt = 0;
      if (!m_busy() && bus.i_req_valid) begin
         acc_evt = 1;
         if (bus.i_req_num == 4'd15) begin
            m_has = 1; m_acc_ue = ue + 1; m_mrc = bus.i_req_is_mrc;
            m_num = bus.i_req_num; m_crn = bus.i_req_crn; m_crm = bus.i_req_crm;
            m_o1 = bus.i_req_opcode1; m_o2 = bus.i_req_opcode2;
            m_rd = bus.i_req_rd; m_wd = bus.i_req_wdata;
         end else begin
            m_undef_has = 1; m_undef_ue = ue + 1;
         end
      end
      ue++;
      if (m_has && !m_mrc && ue == m_acc_ue + 1 && m_crn != 0) mregs[m_crn] = m_wd;
      if (m_has && m_mrc && ue == m_acc_ue + 2) begin
         m_rdata = mregs[m_crn]; m_rdata_rd = m_rd;
      end
   endtask

   // one clock: stub write and model step at the edge, return 2 time units after it
   task automatic tick();
      bit          w_en;
      logic [3:0]  w_crn;
      logic [31:0] w_data;
      bit          live;
      w_en   = rst_n && !stall && bus.o_copro_operation == 2'd2 && bus.o_copro_crn != 0;
      w_crn  = bus.o_copro_crn;
      w_data = bus.o_copro_write_data;
      live   = rst_n && !stall;
      @(posedge clk);
      if (live) model_edge(); else acc_evt = 0;
      #2;
      if (w_en) sregs[w_crn] = w_data;
   endtask

   task automatic set_req(input bit mrc, input logic [3:0] num, input logic [3:0] crn,
                          input logic [3:0] rd, input logic [31:0] wd);
      bus.i_req_is_mrc  = mrc;
      bus.i_req_num     = num;
      bus.i_req_crn     = crn;
      bus.i_req_crm     = 4'(crn + 1);
      bus.i_req_opcode1 = 3'(num);
      bus.i_req_opcode2 = 3'(rd);
      bus.i_req_rd      = rd;
      bus.i_req_wdata   = wd;
   endtask

   // present a request until the model accepts it
   task automatic issue_req(input bit mrc, input logic [3:0] num, input logic [3:0] crn,
                            input logic [3:0] rd, input logic [31:0] wd);
      int n = 0;
      stall = 0;
      set_req(mrc, num, crn, rd, wd);
      bus.i_req_valid = 1;
      do begin
         tick();
         n++;
      end while (!acc_evt && n < 20);
      if (!acc_evt) chk("accept_timeout", 32'(n), 32'(0));
      bus.i_req_valid = 0;
   endtask

   // compare every cycle against the model
   always @(negedge clk) begin : compare
      logic [1:0] op_e;
      bit         busy_e;
      if (chk_en) begin
         op_e   = (m_has && ue == m_acc_ue) ? (m_mrc ? 2'd1 : 2'd2) : 2'd0;
         busy_e = m_busy();
         chk("operation",  32'(bus.o_copro_operation), 32'(op_e));
         chk("num",        32'(bus.o_copro_num), 32'(m_num));
         chk("crn",        32'(bus.o_copro_crn), 32'(m_crn));
         chk("crm",        32'(bus.o_copro_crm), 32'(m_crm));
         chk("opcode1",    32'(bus.o_copro_opcode1), 32'(m_o1));
         chk("opcode2",    32'(bus.o_copro_opcode2), 32'(m_o2));
         chk("write_data", bus.o_copro_write_data, m_mrc ? 32'd0 : m_wd);
         chk("rdata_valid", 32'(bus.o_rdata_valid), 32'(m_has && m_mrc && ue == m_acc_ue + 2));
         chk("rdata",      bus.o_rdata, m_rdata);
         chk("rdata_rd",   32'(bus.o_rdata_rd), 32'(m_rdata_rd));
         chk("undef",      32'(bus.o_undef), 32'(m_undef_has && ue == m_undef_ue));
         chk("busy",       32'(bus.o_busy), 32'(busy_e));
         chk("req_ready",  32'(bus.o_req_ready), 32'(!busy_e && !stall));
      end
   end

   initial begin
      int cnt_a, cnt_b, acc;
      for (int i = 0; i < 16; i++) begin
         sregs[i] = 32'($urandom);
      end
      sregs[0] = ID_REG;
      sregs[7] = FAULT_ADDR;
      for (int i = 0; i < 16; i++) mregs[i] = sregs[i];
      ue = 0; acc_evt = 0; m_acc_ue = 0; m_undef_ue = 0;
      stall = 0;
      bus.i_req_valid = 0;
      set_req(0, 0, 0, 0, 0);
      rst_n = 1;
      #1 rst_n = 0;
      m_reset();
      chk_en = 1;
      #1;
      chk("reset_op",    32'(bus.o_copro_operation), 32'd0);
      chk("reset_valid", 32'(bus.o_rdata_valid), 32'd0);
      chk("reset_rdata", bus.o_rdata, 32'd0);
      chk("reset_busy",  32'(bus.o_busy), 32'd0);
      tick(); tick();
      rst_n = 1;

      // MCR then MRC of the same register
      issue_req(0, 15, 3, 0, 32'hFFFF_0000);
      chk("mcr_op",  32'(bus.o_copro_operation), 32'd2);
      chk("mcr_crn", 32'(bus.o_copro_crn), 32'd3);
      chk("mcr_wd",  bus.o_copro_write_data, 32'hFFFF_0000);
      tick();
      chk("mcr_op_end", 32'(bus.o_copro_operation), 32'd0);
      issue_req(1, 15, 3, 1, 32'h1234_5678);
      chk("mrc_op", 32'(bus.o_copro_operation), 32'd1);
      chk("mrc_wd", bus.o_copro_write_data, 32'd0);
      tick(); tick();
      chk("rb_valid", 32'(bus.o_rdata_valid), 32'd1);
      chk("rb_data",  bus.o_rdata, 32'hFFFF_0000);

      // ID register read
      issue_req(1, 15, 0, 5, 0);
      tick(); tick();
      chk("id_valid", 32'(bus.o_rdata_valid), 32'd1);
      chk("id_data",  bus.o_rdata, 32'h4156_0300);
      chk("id_rd",    32'(bus.o_rdata_rd), 32'd5);
      tick();
      chk("id_valid_end", 32'(bus.o_rdata_valid), 32'd0);
      chk("id_data_hold", bus.o_rdata, 32'h4156_0300);

      // wrong coprocessor number
      issue_req(1, 14, 2, 3, 0);
      chk("undef_pulse", 32'(bus.o_undef), 32'd1);
      chk("undef_op",    32'(bus.o_copro_operation), 32'd0);
      tick();
      chk("undef_end",   32'(bus.o_undef), 32'd0);
      chk("undef_novalid", 32'(bus.o_rdata_valid), 32'd0);

      // stalls during ISSUE and WAIT
      cnt_a = 0; cnt_b = 0;
      issue_req(1, 15, 7, 2, 0);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.o_copro_operation == 2'd1) cnt_a++;
      end
      chk("stall_issue_hold", 32'(cnt_a), 32'd3);
      stall = 0; tick();
      if (bus.o_rdata_valid) cnt_b++;
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (bus.o_rdata_valid) cnt_b++;
      end
      stall = 0; tick();
      if (bus.o_rdata_valid) cnt_b++;
      chk("stall_data", bus.o_rdata, FAULT_ADDR);
      tick();
      if (bus.o_rdata_valid) cnt_b++;
      chk("stall_valid_count", 32'(cnt_b), 32'd1);

      // back-to-back MCRs with valid held
      cnt_a = 0; cnt_b = 0; acc = 0;
      set_req(0, 15, 1, 0, 32'hA5A5_0001);
      bus.i_req_valid = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (acc_evt) acc++;
         if (acc == 1) set_req(0, 15, 2, 0, 32'hA5A5_0002);
         if (acc >= 2) bus.i_req_valid = 0;
         if (bus.o_copro_operation == 2'd2) cnt_a++;
         if (acc == 1 && !bus.o_req_ready) cnt_b++;
      end
      bus.i_req_valid = 0;
      chk("b2b_issues",    32'(cnt_a), 32'd2);
      chk("b2b_ready_low", 32'(cnt_b), 32'd1);

      // reset while waiting for MRC data
      issue_req(1, 15, 1, 4, 0);
      tick();
      rst_n = 0;
      m_reset();
      #1;
      chk("rst_op",    32'(bus.o_copro_operation), 32'd0);
      chk("rst_crn",   32'(bus.o_copro_crn), 32'd0);
      chk("rst_valid", 32'(bus.o_rdata_valid), 32'd0);
      chk("rst_rdata", bus.o_rdata, 32'd0);
      chk("rst_busy",  32'(bus.o_busy), 32'd0);
      tick();
      rst_n = 1;
      cnt_a = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.o_rdata_valid || bus.o_copro_operation != 2'd0) cnt_a++;
      end
      chk("rst_abandon", 32'(cnt_a), 32'd0);

      // random traffic with stalls and occasional resets
      for (int i = 0; i < 600; i++) begin
         stall = ($urandom_range(0, 3) == 0);
         bus.i_req_valid = 1'($urandom_range(0, 1));
         set_req(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd15,
                 4'($urandom), 4'($urandom), 32'($urandom));
         bus.i_req_crm     = 4'($urandom);
         bus.i_req_opcode1 = 3'($urandom);
         bus.i_req_opcode2 = 3'($urandom);
         if ($urandom_range(0, 149) == 0) begin
            rst_n = 0;
            m_reset();
            tick();
            rst_n = 1;
         end
         tick();
      end
      stall = 0;
      bus.i_req_valid = 0;
      tick(); tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
